uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 4..65535.
REQ-002 SHALL have parameter DEPTH, default 16; receive buffer entries, power of two.
REQ-003 SHALL have port clk_fifo_rx, input, 1; the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1; serial line, 8N1 framing, idle high, LSB first.
REQ-006 SHALL have port rd_en, input, 1; host pop request.
REQ-007 SHALL have port clr_err, input, 1; clears sticky error flags.
REQ-008 SHALL have port data_out, output, 8; popped byte.
REQ-009 SHALL have port data_valid, output, 1; one-cycle strobe qualifying data_out.
REQ-010 SHALL have port fifo_rx_status, output, 1; high when the buffer holds at least one byte.
REQ-011 SHALL have port fifo_full, output, 1; high when count equals DEPTH.
REQ-012 SHALL have port overrun, output, 1; sticky; a received byte was dropped because the buffer was full.
REQ-013 SHALL have port frame_err, output, 1; sticky; a stop bit was sampled low.

Function
REQ-014 SHALL pass rx through a two-flop synchroniser with both stages resetting to 1; only the synchronised value is used.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: SHALL go to START on a synchronised falling edge (previous 1, current 0), with the bit counter cleared.
REQ-017 START: SHALL sample at count CLKS_PER_BIT/2-1; if low, go to DATA with the counter cleared; if high, treat as a glitch and return to IDLE.
REQ-018 DATA: SHALL sample at every CLKS_PER_BIT-1 count, shifting LSB first into the shift register; after the 8th sample, go to STOP.
REQ-019 STOP: SHALL sample at CLKS_PER_BIT-1 and return to IDLE. If high, the byte is pushed. If low, frame_err is set and the byte is discarded.
REQ-020 A push SHALL write mem[wr_ptr] in the cycle after the stop sample, increment wr_ptr modulo DEPTH, and increment count.
REQ-021 A push while count==DEPTH SHALL leave mem, wr_ptr and count unchanged and set overrun.
REQ-022 A pop SHALL occur when rd_en is high and count>0. On the next edge, data_out gets mem[rd_ptr], data_valid goes high for 1 cycle, rd_ptr increments modulo DEPTH, and count decrements.
REQ-023 rd_en with count==0 SHALL be ignored: data_out holds its value and data_valid stays low.
REQ-024 A simultaneous push and pop SHALL both complete and leave count unchanged; a pop from an empty buffer does not see a same-cycle push.
REQ-025 The pointers SHALL be log2(DEPTH) bits and count SHALL be log2(DEPTH)+1 bits; the pointers wrap naturally.
REQ-026 fifo_rx_status and fifo_full SHALL be registered decodes of count, updated in the same cycle as count.
REQ-027 clr_err SHALL clear overrun and frame_err on the next edge; a set event in the same cycle SHALL take priority over the clear.
REQ-028 Receive latency: the push SHALL occur CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after the falling edge on rx.

Reset
REQ-029 On rst the FSM SHALL go to IDLE; counters, pointers and count go to 0; synchroniser flops go to 1.
REQ-030 On rst the outputs SHALL be: data_out=8'h00, data_valid=0, fifo_rx_status=0, fifo_full=0, overrun=0, frame_err=0.
REQ-031 Reset mid-frame SHALL abandon the frame; after release the block resynchronises on the next falling edge.
REQ-032 Buffer memory contents SHALL NOT require reset.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state encoding, the data width (8) and the default CLKS_PER_BIT; the TX path uses the same package.
REQ-034 The buffer SHALL be a sub-module fifo_rx (push/pop/count/full/empty). The FSM, synchroniser and error flags stay in the top module.

Verification (CLKS_PER_BIT=16, DEPTH=16)
REQ-035 Send 8'hA5 with a valid stop bit, then pulse rd_en -> after 1 cycle data_out=8'hA5 and data_valid=1 for 1 cycle; fifo_rx_status goes 1 then 0.
REQ-036 Send 17 bytes 8'h00..8'h10 without reading -> fifo_full=1 and overrun=1; 16 pops return 8'h00..8'h0F in order; 8'h10 is lost.
REQ-037 Send 8'h3C with the stop bit low -> frame_err=1 and count stays 0; clr_err -> frame_err=0 on the next edge.
REQ-038 Pulse rx low for 4 cycles -> FSM returns to IDLE and no push occurs.
REQ-039 Hold rd_en high while a byte pushes at count=1 -> count stays 1 and data_out is the older byte.
REQ-040 Assert rst during DATA of byte 8'hFF, then send 8'h5A -> only 8'h5A is stored and all outputs held their reset values during rst.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, data width and default bit timing.
package uart_pkg;

  localparam int DATA_W               = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/fifo_rx.sv
// Receive byte buffer: circular memory with registered pop data/strobe and registered full/non-empty decodes.
module fifo_rx
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              full_q, full_d;
  logic              not_empty_q, not_empty_d;
  logic              do_push, do_pop;

  // A pop only sees entries already present, so an empty buffer ignores a same-cycle push.
  always_comb begin
    do_push     = push && (count_q != CW'(DEPTH));
    do_pop      = pop && (count_q != '0);
    wr_ptr_d    = wr_ptr_q + AW'(do_push);
    rd_ptr_d    = rd_ptr_q + AW'(do_pop);
    count_d     = count_q + CW'(do_push) - CW'(do_pop);
    pop_data_d  = do_pop ? mem[rd_ptr_q] : pop_data_q;
    pop_valid_d = do_pop;
    full_d      = (count_d == CW'(DEPTH));
    not_empty_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      full_q      <= 1'b0;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      full_q      <= full_d;
      not_empty_q <= not_empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign full      = full_q;
  assign not_empty = not_empty_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchroniser, oversampling FSM and sticky error flags feeding a receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH        = 16
) (
  input  logic              clk_fifo_rx,
  input  logic              rst,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_rx_status,
  output logic              fifo_full,
  output logic              overrun,
  output logic              frame_err
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e       state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push_q, push_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              frame_set;
  logic              buf_full;

  // Start sample lands mid start bit; every later sample is one full bit apart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + 16'd1;
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          push_d    = rx_sync_q;
          frame_set = !rx_sync_q;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    frame_err_d = frame_set | (frame_err_q & ~clr_err);
    overrun_d   = (push_q & buf_full) | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk_fifo_rx or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  fifo_rx #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk_fifo_rx),
    .rst       (rst),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rd_en),
    .pop_data  (data_out),
    .pop_valid (data_valid),
    .full      (buf_full),
    .not_empty (fifo_rx_status)
  );

  assign fifo_full = buf_full;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
